// File: rtl/data_mem_unit.sv
// Word-organised big-endian data memory with a valid/ready request port and a registered response.
// Accesses that cross a word boundary take a second beat on the following word.
module data_mem_unit #(
    parameter int    DEPTH_WORDS    = 256,
    parameter int    ADDR_W         = 32,
    parameter int    OUT_WORD       = 2,
    parameter int    MISALIGN_SPLIT = 1,
    parameter string INIT_FILE      = ""
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       out_data
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W:0] CAP = (ADDR_W + 1)'(4 * DEPTH_WORDS);

    typedef enum logic {IDLE, SPLIT} state_t;
    typedef logic [DEPTH_WORDS-1:0][31:0] image_t;

    function automatic image_t initImage();
        image_t      img;
        img = '0;
        img[0] = 32'h0000_0009;
        if (DEPTH_WORDS > 1) img[1] = 32'h0000_000C;
        return img;
    endfunction

    // Pulls the accessed bytes out of a two-word window (first word high) and extends them.
    function automatic logic [31:0] extractLoad(input logic [63:0] window, input logic [1:0] off,
                                                input logic [1:0] size, input logic uns);
        logic [31:0] raw;
        logic [31:0] res;
        int          nBytes;
        nBytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        raw    = 32'(window >> (8 * (8 - int'(off) - nBytes)));
        case (size)
            2'b00:   res = uns ? {24'h0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
            2'b01:   res = uns ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

    image_t mem_q = initImage();

    state_t            state_q, state_d;
    logic              rspValid_q, rspValid_d;
    logic [31:0]       rspRdata_q, rspRdata_d;
    logic              rspErr_q, rspErr_d;
    logic [31:0]       outData_q;
    logic [IDX_W-1:0]  splitIdx_q, splitIdx_d;
    logic [31:0]       splitData_q, splitData_d;
    logic [31:0]       splitMask_q, splitMask_d;
    logic [31:0]       hiWord_q, hiWord_d;
    logic              splitWe_q, splitWe_d;
    logic              splitUns_q, splitUns_d;
    logic [1:0]        splitSize_q, splitSize_d;
    logic [1:0]        splitOff_q, splitOff_d;

    logic [2:0]        reqBytes;
    logic [1:0]        reqOff;
    logic [IDX_W-1:0]  reqIdx;
    logic [ADDR_W:0]   endAddr;
    logic              reqCross;
    logic              reqErr;
    logic [63:0]       storeWin;
    logic [63:0]       maskWin;

    logic              wrEn;
    logic [IDX_W-1:0]  wrIdx;
    logic [31:0]       wrData;
    logic [31:0]       wrMask;
    logic [31:0]       newWord;

    always_comb begin
        case (req_size)
            2'b01:   reqBytes = 3'd2;
            2'b10:   reqBytes = 3'd4;
            default: reqBytes = 3'd1;
        endcase
        reqOff   = req_addr[1:0];
        reqIdx   = req_addr[IDX_W+1:2];
        endAddr  = {1'b0, req_addr} + (ADDR_W + 1)'(reqBytes - 3'd1);
        reqCross = ({2'b00, reqOff} + {1'b0, reqBytes}) > 4'd4;
        reqErr   = (req_size == 2'b11) || (endAddr >= CAP) || (reqCross && (MISALIGN_SPLIT == 0));
        // Store bytes and enables are laid out over words A>>2 and (A>>2)+1 as one 8-byte window.
        storeWin = {32'h0, req_wdata} << (8 * (8 - int'(reqOff) - int'(reqBytes)));
        maskWin  = '0;
        for (int j = 0; j < 8; j++) begin
            maskWin[63 - 8*j -: 8] = ((j >= int'(reqOff)) && (j < int'(reqOff) + int'(reqBytes))) ? 8'hFF : 8'h00;
        end
    end

    always_comb begin
        state_d     = state_q;
        rspValid_d  = 1'b0;
        rspRdata_d  = 32'h0;
        rspErr_d    = 1'b0;
        splitIdx_d  = splitIdx_q;
        splitData_d = splitData_q;
        splitMask_d = splitMask_q;
        hiWord_d    = hiWord_q;
        splitWe_d   = splitWe_q;
        splitUns_d  = splitUns_q;
        splitSize_d = splitSize_q;
        splitOff_d  = splitOff_q;
        wrEn        = 1'b0;
        wrIdx       = reqIdx;
        wrData      = storeWin[63:32];
        wrMask      = maskWin[63:32];
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (reqErr) begin
                        rspValid_d = 1'b1;
                        rspErr_d   = 1'b1;
                    end else begin
                        wrEn = req_we;
                        if (reqCross) begin
                            state_d     = SPLIT;
                            splitIdx_d  = reqIdx + IDX_W'(1);
                            splitData_d = storeWin[31:0];
                            splitMask_d = maskWin[31:0];
                            hiWord_d    = mem_q[reqIdx];
                            splitWe_d   = req_we;
                            splitUns_d  = req_unsigned;
                            splitSize_d = req_size;
                            splitOff_d  = reqOff;
                        end else begin
                            rspValid_d = 1'b1;
                            rspRdata_d = req_we ? 32'h0
                                       : extractLoad({mem_q[reqIdx], 32'h0}, reqOff, req_size, req_unsigned);
                        end
                    end
                end
            end
            SPLIT: begin
                state_d    = IDLE;
                rspValid_d = 1'b1;
                wrEn       = splitWe_q;
                wrIdx      = splitIdx_q;
                wrData     = splitData_q;
                wrMask     = splitMask_q;
                rspRdata_d = splitWe_q ? 32'h0
                           : extractLoad({hiWord_q, mem_q[splitIdx_q]}, splitOff_q, splitSize_q, splitUns_q);
            end
            default: state_d = IDLE;
        endcase
        wrEn    = wrEn && !reset;
        newWord = (mem_q[wrIdx] & ~wrMask) | (wrData & wrMask);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            rspValid_q  <= 1'b0;
            rspRdata_q  <= 32'h0;
            rspErr_q    <= 1'b0;
            outData_q   <= 32'h0;
            splitIdx_q  <= '0;
            splitData_q <= 32'h0;
            splitMask_q <= 32'h0;
            hiWord_q    <= 32'h0;
            splitWe_q   <= 1'b0;
            splitUns_q  <= 1'b0;
            splitSize_q <= 2'b00;
            splitOff_q  <= 2'b00;
        end else begin
            state_q     <= state_d;
            rspValid_q  <= rspValid_d;
            rspRdata_q  <= rspRdata_d;
            rspErr_q    <= rspErr_d;
            splitIdx_q  <= splitIdx_d;
            splitData_q <= splitData_d;
            splitMask_q <= splitMask_d;
            hiWord_q    <= hiWord_d;
            splitWe_q   <= splitWe_d;
            splitUns_q  <= splitUns_d;
            splitSize_q <= splitSize_d;
            splitOff_q  <= splitOff_d;
            if (wrEn && (wrIdx == IDX_W'(OUT_WORD))) outData_q <= newWord;
        end
    end

    // The array keeps its contents across reset.
    always_ff @(posedge clk) begin
        if (wrEn) mem_q[wrIdx] <= newWord;
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rspValid_q;
    assign rsp_rdata = rspRdata_q;
    assign rsp_err   = rspErr_q;
    assign out_data  = outData_q;

endmodule
